// File: rtl/mem_bus_arbiter.sv
// Two-master memory bus arbiter (I and M side), tenure-locked with round-robin on ties.
// Latency: grant 1 cycle after request; backpressure: the non-owner waits until the owner drops its request.
module mem_bus_arbiter #(
    parameter int addrbits = 32,
    parameter int databits = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                HRequestI,
    input  logic [addrbits-1:0] HAddrI,
    input  logic                HRequestM,
    input  logic                HWriteM,
    input  logic [addrbits-1:0] HAddrM,
    input  logic [databits-1:0] HWDataM,
    input  logic                BusReady,
    output logic                HRequest,
    output logic                HWrite,
    output logic [addrbits-1:0] HAddr,
    output logic [databits-1:0] HWData,
    output logic                BusReadyI,
    output logic                BusReadyM,
    output logic                GrantI,
    output logic                GrantM,
    output logic [3:0]          BeatCount
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_M = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   last_m;
    logic   last_m_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last_m    <= 1'b0;
            BeatCount <= 4'd0;
        end else begin
            state  <= state_next;
            last_m <= last_m_next;
            // A beat landing in the release cycle is dropped by the clear on grant change.
            if (state_next != state)
                BeatCount <= 4'd0;
            else if (state != IDLE && BusReady && BeatCount != 4'd15)
                BeatCount <= BeatCount + 4'd1;
        end
    end

    always_comb begin
        state_next  = state;
        last_m_next = last_m;
        case (state)
            IDLE: begin
                if (HRequestM && HRequestI)
                    state_next = last_m ? OWN_I : OWN_M;
                else if (HRequestM)
                    state_next = OWN_M;
                else if (HRequestI)
                    state_next = OWN_I;
            end
            OWN_M: begin
                if (!HRequestM) begin
                    state_next  = HRequestI ? OWN_I : IDLE;
                    last_m_next = 1'b1;
                end
            end
            OWN_I: begin
                if (!HRequestI) begin
                    state_next  = HRequestM ? OWN_M : IDLE;
                    last_m_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        HRequest = 1'b0;
        HWrite   = 1'b0;
        HAddr    = '0;
        HWData   = '0;
        GrantI   = (state == OWN_I);
        GrantM   = (state == OWN_M);
        if (GrantM) begin
            HRequest = HRequestM;
            HWrite   = HWriteM;
            HAddr    = HAddrM;
            HWData   = HWDataM;
        end else if (GrantI) begin
            HRequest = HRequestI;
            HAddr    = HAddrI;
        end
        BusReadyI = BusReady & GrantI;
        BusReadyM = BusReady & GrantM;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: checks grants, bus muxing, ready routing and beat counting.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        hri, hrm, hwm, br;
    logic [31:0] hai, ham, hwd;
    logic        HRequest, HWrite, BusReadyI, BusReadyM, GrantI, GrantM;
    logic [31:0] HAddr, HWData;
    logic [3:0]  BeatCount;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.addrbits(32), .databits(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .HRequestI (hri),
        .HAddrI    (hai),
        .HRequestM (hrm),
        .HWriteM   (hwm),
        .HAddrM    (ham),
        .HWDataM   (hwd),
        .BusReady  (br),
        .HRequest  (HRequest),
        .HWrite    (HWrite),
        .HAddr     (HAddr),
        .HWData    (HWData),
        .BusReadyI (BusReadyI),
        .BusReadyM (BusReadyM),
        .GrantI    (GrantI),
        .GrantM    (GrantM),
        .BeatCount (BeatCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        hri = 1'b0; hrm = 1'b0; hwm = 1'b1; br = 1'b1;
        hai = 32'h66; ham = 32'h55; hwd = 32'h77;
        tick();
        tick();
        #1;
        chk("rst_granti", GrantI, 0);
        chk("rst_grantm", GrantM, 0);
        chk("rst_hreq", HRequest, 0);
        chk("rst_hwrite", HWrite, 0);
        chk("rst_haddr", HAddr, 0);
        chk("rst_hwdata", HWData, 0);
        chk("rst_beats", BeatCount, 0);
        chk("rst_rdym", BusReadyM, 0);

        // I side 4-beat refill
        reset = 1'b0; br = 1'b0; hwm = 1'b0;
        hri = 1'b1; hai = 32'h100; hwd = 32'hABCD;
        #1;
        chk("t1_lat_grant", GrantI, 0);
        chk("t1_lat_hreq", HRequest, 0);
        tick();
        chk("t1_granti", GrantI, 1);
        chk("t1_hreq", HRequest, 1);
        chk("t1_haddr", HAddr, 32'h100);
        chk("t1_hwdata", HWData, 0);
        for (int i = 1; i <= 4; i++) begin
            br = 1'b1;
            #1;
            chk("t1_rdyi", BusReadyI, 1);
            chk("t1_rdym", BusReadyM, 0);
            tick();
            chk("t1_beats", BeatCount, i);
        end
        br = 1'b0; hri = 1'b0;
        #1;
        chk("t1_rel_hreq", HRequest, 0);
        tick();
        chk("t1_idle_i", GrantI, 0);
        chk("t1_idle_m", GrantM, 0);
        chk("t1_idle_beats", BeatCount, 0);

        // Simultaneous requests with LastM=0: M first, 8-beat writeback+refill
        hri = 1'b1; hrm = 1'b1; hai = 32'h300;
        tick();
        chk("t2_grantm", GrantM, 1);
        chk("t2_granti", GrantI, 0);
        for (int k = 1; k <= 8; k++) begin
            hwm = (k <= 4);
            ham = 32'h2000 + 32'(k * 4);
            hwd = 32'(k);
            br  = 1'b1;
            #1;
            chk("t2_hwrite", HWrite, (k <= 4) ? 1 : 0);
            chk("t2_haddr", HAddr, 32'h2000 + 32'(k * 4));
            chk("t2_hwdata", HWData, k);
            chk("t2_rdym", BusReadyM, 1);
            chk("t2_rdyi", BusReadyI, 0);
            tick();
            chk("t2_beats", BeatCount, k);
        end
        hrm = 1'b0; br = 1'b0; hwm = 1'b0;
        tick();
        chk("t2_handoff_i", GrantI, 1);
        chk("t2_handoff_m", GrantM, 0);
        chk("t2_handoff_beats", BeatCount, 0);
        chk("t2_handoff_addr", HAddr, 32'h300);

        // I owns, M requests mid-tenure, BusReady toggles
        for (int i = 0; i < 6; i++) begin
            br = (i % 2 == 1);
            if (i == 2) hrm = 1'b1;
            #1;
            chk("t3_grantm_hold", GrantM, 0);
            chk("t3_rdym", BusReadyM, 0);
            chk("t3_rdyi", BusReadyI, (i % 2 == 1) ? 1 : 0);
            tick();
        end
        chk("t3_beats", BeatCount, 3);
        hri = 1'b0; br = 1'b0;
        tick();
        chk("t3_grantm", GrantM, 1);
        chk("t3_beats_clr", BeatCount, 0);

        // Alternation: both re-request continuously, 4-beat tenures
        hri = 1'b1;
        for (int t = 0; t < 4; t++) begin
            chk("t4_grantm", GrantM, (t % 2 == 0) ? 1 : 0);
            chk("t4_granti", GrantI, (t % 2 == 0) ? 0 : 1);
            br = 1'b1;
            for (int b = 0; b < 4; b++) tick();
            chk("t4_beats", BeatCount, 4);
            br = 1'b0;
            if (t % 2 == 0) hrm = 1'b0; else hri = 1'b0;
            tick();
            hrm = 1'b1; hri = 1'b1;
        end
        chk("t4_final_m", GrantM, 1);
        hrm = 1'b0; hri = 1'b0;
        tick();
        chk("t4_idle_m", GrantM, 0);
        chk("t4_idle_i", GrantI, 0);

        // Uncached single write, request drops with the beat
        hrm = 1'b1; hwm = 1'b1; ham = 32'h0000_1F04; hwd = 32'hDEADBEEF;
        tick();
        br = 1'b1; hrm = 1'b0;
        #1;
        chk("t5_haddr", HAddr, 32'h0000_1F04);
        chk("t5_hwdata", HWData, 32'hDEADBEEF);
        chk("t5_hwrite", HWrite, 1);
        chk("t5_rdym", BusReadyM, 1);
        tick();
        br = 1'b0; hwm = 1'b0;
        #1;
        chk("t5_idle_m", GrantM, 0);
        chk("t5_idle_hreq", HRequest, 0);
        chk("t5_beats", BeatCount, 0);

        // Reset mid-tenure at BeatCount=2
        hrm = 1'b1;
        tick();
        br = 1'b1;
        tick();
        tick();
        chk("t6_beats2", BeatCount, 2);
        br = 1'b0; reset = 1'b1; hri = 1'b1;
        tick();
        chk("t6_rst_grantm", GrantM, 0);
        chk("t6_rst_hreq", HRequest, 0);
        chk("t6_rst_beats", BeatCount, 0);
        reset = 1'b0;
        #1;
        chk("t6_lat_m", GrantM, 0);
        chk("t6_lat_i", GrantI, 0);
        tick();
        chk("t6_grantm", GrantM, 1);
        chk("t6_granti", GrantI, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master arbiter that shares the single external memory bus between the instruction cache controller (I side) and the data cache controller (M side).
- It grants bus ownership, muxes address, write data and direction onto the bus, and routes BusReady back only to the owner.
- Ownership is locked for a whole tenure: a writeback burst plus refill burst, a refill, or a single uncached write.
- It sits between both cache controllers and the memory interface.

Parameters:
- addrbits, 32, width of bus address.
- databits, 32, width of bus write data.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- HRequestI  in  1  instruction side bus request; held high for the whole tenure
- HAddrI  in  addrbits  instruction side address
- HRequestM  in  1  data side bus request; held high for the whole tenure
- HWriteM  in  1  data side write (writeback or uncached write)
- HAddrM  in  addrbits  data side address
- HWDataM  in  databits  data side write data
- BusReady  in  1  memory beat-complete strobe
- HRequest  out  1  request to memory
- HWrite  out  1  write to memory
- HAddr  out  addrbits  address to memory
- HWData  out  databits  write data to memory
- BusReadyI  out  1  beat strobe to instruction controller
- BusReadyM  out  1  beat strobe to data controller
- GrantI  out  1  instruction side owns bus
- GrantM  out  1  data side owns bus
- BeatCount  out  4  beats completed in current tenure; saturates at 15

Behaviour:
- All state registers update on posedge clk. reset is sampled synchronously.
- Reset values: state=IDLE, LastM=0, BeatCount=0. All outputs are 0, and HAddr/HWData are 0.
- States: IDLE, OWN_I, OWN_M.
- Transitions from IDLE:
  - Only HRequestM high -> OWN_M.
  - Only HRequestI high -> OWN_I.
  - Both high -> round-robin: if LastM=1 then OWN_I, else OWN_M.
  - Neither high -> stay in IDLE.
- Arbitration latency is 1 cycle. HRequest=0 in IDLE, so the first bus request is issued in the cycle after the requester asserts.
- OWN_M:
  - Hold while HRequestM=1.
  - When HRequestM=0: go to OWN_I if HRequestI=1 (no idle bubble), else IDLE.
  - Set LastM<=1 on exit.
- OWN_I:
  - Symmetric to OWN_M.
  - Set LastM<=0 on exit.
- A grant never changes while the owner's request is high. The other requester waits unconditionally; there is no preemption.
- GrantI=(state==OWN_I) and GrantM=(state==OWN_M), both combinational from state.
- Bus muxing:
  - OWN_M: HRequest=HRequestM, HWrite=HWriteM, HAddr=HAddrM, HWData=HWDataM.
  - OWN_I: HRequest=HRequestI, HWrite=0, HAddr=HAddrI, HWData=0.
  - IDLE: HRequest=0, HWrite=0, HAddr=0, HWData=0.
- Ready routing: BusReadyM=BusReady&GrantM and BusReadyI=BusReady&GrantI.
  - A non-owner never sees a ready strobe, so its internal beat counter holds.
  - BusReady arriving in IDLE is ignored.
- BeatCount:
  - Clears to 0 on every grant change (including entering IDLE).
  - Otherwise increments on BusReady while owned, saturating at 15.
  - A beat arriving in the same cycle as owner release is not counted.
- Owner request drops in the same cycle BusReady is high: the beat belongs to the current owner (BusReadyx=1 that cycle), then the hand-off occurs.
- Both requests rise in the same cycle as the owner releases: the non-owner wins, because the grant alternates.
- Reset during a tenure: return to IDLE next edge. The grant is dropped and HRequest=0 from that edge; requesters are reset by the same signal.

Test Plan:
- Reset, then HRequestI=1 at cycle 2, BusReady every cycle for 4 beats, then HRequestI=0.
  - Required: GrantI=1 from cycle 3, HRequest=1 cycles 3-6, BusReadyI pulses 4 times, BeatCount reaches 4, IDLE after release, BusReadyM=0 throughout.
- Both requests rise together after reset (LastM=0).
  - Required: OWN_M first.
  - Data side does an 8-beat writeback+refill with HWriteM=1 for beats 1-4 and 0 for beats 5-8: HWrite follows HWriteM, HAddr=HAddrM.
  - On HRequestM fall: GrantI=1 on the next edge with no IDLE cycle, BeatCount=0.
- Instruction side owns the bus, data side requests mid-tenure with BusReady toggling.
  - Required: GrantM stays 0 and BusReadyM=0 until HRequestI falls; LastM=0 at hand-off; data side granted next.
- Alternation: both requesters continuously re-request, each using 4-beat tenures.
  - Required: grants alternate M,I,M,I; neither side gets two consecutive tenures while the other waits.
- Uncached single write: HRequestM=1, HWriteM=1, HAddrM=0x0000_1F04, HWDataM=0xDEADBEEF, one BusReady, request drops in the same cycle.
  - Required: the bus carries that address and data, BusReadyM=1 for that beat, IDLE next cycle, BeatCount=0.
- Assert reset for one cycle during OWN_M at BeatCount=2.
  - Required: the next edge gives IDLE, GrantM=0, HRequest=0, BeatCount=0; a request arriving after reset is granted 1 cycle later.
